bp_cfg_boot_sequencer: RTL and testbench
========================================

// Module: bp_cfg_boot_sequencer
// PURPOSE
//  Boot-time config master for the cfg link into every core tile.
//  After reset (or on start_i), per core: freeze, write core id, load CCE microcode from an external ROM,
//  set CCE mode; then unfreeze all cores and assert done_o. Sits between the testbench/host ROM and the tile cfg ports.
// PARAMETERS
//  num_core_p         1    cores to configure (1..2^cfg_core_width_p)
//  cfg_core_width_p   8    cfg core-select width
//  cfg_addr_width_p   16   cfg register address width
//  cfg_data_width_p   64   cfg write data width
//  cce_pc_width_p     8    microcode ROM address width
//  cce_instr_width_p  48   microcode word width (<= cfg_data_width_p)
//  ucode_els_p        256  microcode words loaded per core (1..2^cce_pc_width_p)
// PORTS
//  clk_i        in   1                   clock
//  reset_i      in   1                   async reset, active-high
//  start_i      in   1                   pulse: rerun sequence; honoured only in IDLE/DONE
//  rom_addr_o   out  cce_pc_width_p      microcode ROM address
//  rom_v_o      out  1                   ROM read enable
//  rom_data_i   in   cce_instr_width_p   ROM word, valid 1 cycle after rom_v_o
//  cfg_v_o      out  1                   cfg write valid
//  cfg_ready_i  in   1                   cfg write accepted when cfg_v_o & cfg_ready_i
//  cfg_core_o   out  cfg_core_width_p    target core
//  cfg_addr_o   out  cfg_addr_width_p    register address
//  cfg_data_o   out  cfg_data_width_p    write data
//  busy_o       out  1                   sequence in progress
//  done_o       out  1                   sequence complete, held until start_i/reset
// BEHAVIOUR
//  Reset (async): state=RESET, counters=0, cfg_v_o=0, rom_v_o=0, busy_o=0, done_o=0, addr/data/core outputs 0.
//  First rising edge with reset_i low: RESET->FREEZE automatically (no start_i needed).
//  Register map: 0x0000 freeze (data 1/0), 0x0001 core_id (data=core index, zero-ext),
//    0x0002 cce_mode (data 1 = normal), 0x8000+pc microcode word pc (data=rom_data_i zero-ext).
//  States, core counter c, pc counter p:
//   FREEZE  : write {c,0x0000,1} -> COREID
//   COREID  : write {c,0x0001,c} -> FETCH, p=0
//   FETCH   : rom_v_o=1, rom_addr_o=p, cfg_v_o=0; 1 cycle -> SEND
//   SEND    : capture rom_data_i on entry; write {c,0x8000+p,word};
//             on accept: p==ucode_els_p-1 ? ->MODE : p++,->FETCH
//   MODE    : write {c,0x0002,1}; on accept c==num_core_p-1 ? c=0,->UNFREEZE : c++,->FREEZE
//   UNFREEZE: write {c,0x0000,0}; on accept c==num_core_p-1 ? ->DONE : c++
//   DONE    : done_o=1, busy_o=0; start_i -> c=0, FREEZE, done_o=0 next cycle
//  "write" = assert cfg_v_o with fields; advance only on cfg_v_o&cfg_ready_i. While cfg_v_o&!cfg_ready_i
//    all cfg outputs hold stable (no retraction, no change). cfg_v_o never depends combinationally on cfg_ready_i.
//  Back-to-back: with cfg_ready_i=1 tied, non-ucode writes take 1 cycle each; ucode words 2 cycles (FETCH+SEND).
//  busy_o=1 in all states except RESET-exit-pending and DONE. start_i while busy ignored.
//  Address arithmetic: 0x8000+p computed at cfg_addr_width_p; p width cce_pc_width_p, no wrap since p<ucode_els_p.
//  Core id / ROM word zero-extended to cfg_data_width_p; c zero-extended/truncated to cfg_core_width_p.
//  ROM data captured into a register in SEND's first cycle; later rom_data_i changes do not affect cfg_data_o.
//  Reset asserted mid-sequence: outputs drop to reset values immediately; sequence restarts from core 0 after release.
//  Total accepted writes per run = num_core_p*(ucode_els_p+3) + num_core_p.
// TESTING
//  1 num_core_p=2, ucode_els_p=4, ready=1, ROM[p]=0xA0+p -> 16 writes in order: c0 freeze, id0, 0x8000..0x8003
//    data A0..A3, mode; c1 same; unfreeze c0,c1; done_o=1 on cycle after last accept.
//  2 Random cfg_ready_i stalls (50%) -> identical write trace to test 1; outputs stable across every stall cycle.
//  3 Swap ROM contents to 0xFF.. after each FETCH capture cycle -> cfg_data_o keeps captured value during stall.
//  4 Assert reset_i while in SEND of c1,p=2 -> cfg_v_o=0 asynchronously; after release trace restarts at c0 freeze.
//  5 start_i pulse while busy -> ignored; start_i in DONE -> done_o falls, full 16-write trace repeats.
//  6 num_core_p=1, ucode_els_p=1 -> exactly 5 writes: freeze, id0, 0x8000, mode, unfreeze; then done_o=1.

Source files
------------

// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time cfg-link master: per core freezes, writes core id, streams CCE microcode
// from an external ROM and sets CCE mode, then unfreezes every core and reports done.
module bp_cfg_boot_sequencer #(
    parameter int unsigned num_core_p        = 1,
    parameter int unsigned cfg_core_width_p  = 8,
    parameter int unsigned cfg_addr_width_p  = 16,
    parameter int unsigned cfg_data_width_p  = 64,
    parameter int unsigned cce_pc_width_p    = 8,
    parameter int unsigned cce_instr_width_p = 48,
    parameter int unsigned ucode_els_p       = 256
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    output logic [cce_pc_width_p-1:0]    rom_addr_o,
    output logic                         rom_v_o,
    input  logic [cce_instr_width_p-1:0] rom_data_i,
    output logic                         cfg_v_o,
    input  logic                         cfg_ready_i,
    output logic [cfg_core_width_p-1:0]  cfg_core_o,
    output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
    output logic [cfg_data_width_p-1:0]  cfg_data_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int unsigned core_cnt_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

    localparam logic [core_cnt_width_lp-1:0] core_last_lp = core_cnt_width_lp'(num_core_p - 1);
    localparam logic [cce_pc_width_p-1:0]    pc_last_lp   = cce_pc_width_p'(ucode_els_p - 1);

    localparam logic [cfg_addr_width_p-1:0] addr_freeze_lp = cfg_addr_width_p'(32'h0000_0000);
    localparam logic [cfg_addr_width_p-1:0] addr_core_id_lp = cfg_addr_width_p'(32'h0000_0001);
    localparam logic [cfg_addr_width_p-1:0] addr_cce_mode_lp = cfg_addr_width_p'(32'h0000_0002);
    localparam logic [cfg_addr_width_p-1:0] addr_ucode_lp = cfg_addr_width_p'(32'h0000_8000);

    typedef enum logic [2:0] {
        S_RESET,
        S_FREEZE,
        S_COREID,
        S_FETCH,
        S_SEND,
        S_MODE,
        S_UNFREEZE,
        S_DONE
    } state_e;

    state_e                          state_q, state_n;
    logic [core_cnt_width_lp-1:0]    core_q, core_n;
    logic [cce_pc_width_p-1:0]       pc_q, pc_n;
    logic                            capture_q, capture_n;
    logic [cfg_data_width_p-1:0]     data_q, data_n;

    logic                            accept;
    logic                            cfg_v_n;
    logic                            rom_v_n;
    logic [cce_pc_width_p-1:0]       rom_addr_n;
    logic [cfg_core_width_p-1:0]     cfg_core_n;
    logic [cfg_addr_width_p-1:0]     cfg_addr_n;
    logic                            busy_n;
    logic                            done_n;

    assign accept = cfg_v_o & cfg_ready_i;

    // Next state and counters; a write advances only when the current beat is accepted.
    always_comb begin
        state_n = state_q;
        core_n  = core_q;
        pc_n    = pc_q;
        case (state_q)
            S_RESET: begin
                state_n = S_FREEZE;
                core_n  = '0;
                pc_n    = '0;
            end
            S_FREEZE: begin
                if (accept) state_n = S_COREID;
            end
            S_COREID: begin
                if (accept) begin
                    state_n = S_FETCH;
                    pc_n    = '0;
                end
            end
            S_FETCH: begin
                state_n = S_SEND;
            end
            S_SEND: begin
                if (accept) begin
                    if (pc_q == pc_last_lp) begin
                        state_n = S_MODE;
                    end else begin
                        state_n = S_FETCH;
                        pc_n    = pc_q + cce_pc_width_p'(1);
                    end
                end
            end
            S_MODE: begin
                if (accept) begin
                    if (core_q == core_last_lp) begin
                        state_n = S_UNFREEZE;
                        core_n  = '0;
                    end else begin
                        state_n = S_FREEZE;
                        core_n  = core_q + core_cnt_width_lp'(1);
                    end
                end
            end
            S_UNFREEZE: begin
                if (accept) begin
                    if (core_q == core_last_lp) begin
                        state_n = S_DONE;
                    end else begin
                        core_n = core_q + core_cnt_width_lp'(1);
                    end
                end
            end
            S_DONE: begin
                if (start_i) begin
                    state_n = S_FREEZE;
                    core_n  = '0;
                end
            end
            default: begin
                state_n = S_RESET;
            end
        endcase
    end

    // Output values for the upcoming state; a stalled write recomputes identical fields.
    always_comb begin
        cfg_v_n    = 1'b0;
        rom_v_n    = 1'b0;
        rom_addr_n = '0;
        cfg_core_n = cfg_core_width_p'(core_n);
        cfg_addr_n = '0;
        data_n     = '0;
        busy_n     = 1'b1;
        done_n     = 1'b0;
        capture_n  = (state_q == S_FETCH) && (state_n == S_SEND);
        case (state_n)
            S_RESET: begin
                busy_n     = 1'b0;
                cfg_core_n = '0;
            end
            S_FREEZE: begin
                cfg_v_n    = 1'b1;
                cfg_addr_n = addr_freeze_lp;
                data_n     = cfg_data_width_p'(1);
            end
            S_COREID: begin
                cfg_v_n    = 1'b1;
                cfg_addr_n = addr_core_id_lp;
                data_n     = cfg_data_width_p'(core_n);
            end
            S_FETCH: begin
                rom_v_n    = 1'b1;
                rom_addr_n = pc_n;
            end
            S_SEND: begin
                cfg_v_n    = 1'b1;
                cfg_addr_n = addr_ucode_lp + cfg_addr_width_p'(pc_n);
                data_n     = capture_q ? cfg_data_width_p'(rom_data_i) : data_q;
            end
            S_MODE: begin
                cfg_v_n    = 1'b1;
                cfg_addr_n = addr_cce_mode_lp;
                data_n     = cfg_data_width_p'(1);
            end
            S_UNFREEZE: begin
                cfg_v_n    = 1'b1;
                cfg_addr_n = addr_freeze_lp;
                data_n     = '0;
            end
            S_DONE: begin
                busy_n     = 1'b0;
                done_n     = 1'b1;
                cfg_core_n = '0;
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_RESET;
            core_q     <= '0;
            pc_q       <= '0;
            capture_q  <= 1'b0;
            data_q     <= '0;
            cfg_v_o    <= 1'b0;
            rom_v_o    <= 1'b0;
            rom_addr_o <= '0;
            cfg_core_o <= '0;
            cfg_addr_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state_q    <= state_n;
            core_q     <= core_n;
            pc_q       <= pc_n;
            capture_q  <= capture_n;
            data_q     <= data_n;
            cfg_v_o    <= cfg_v_n;
            rom_v_o    <= rom_v_n;
            rom_addr_o <= rom_addr_n;
            cfg_core_o <= cfg_core_n;
            cfg_addr_o <= cfg_addr_n;
            busy_o     <= busy_n;
            done_o     <= done_n;
        end
    end

    // The ROM word only arrives in SEND's first cycle, so it is forwarded then and held after.
    assign cfg_data_o = capture_q ? cfg_data_width_p'(rom_data_i) : data_q;

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Bench for bp_cfg_boot_sequencer: two configurations checked every cycle against
// an expected write trace built from the register-map rules, with random ready stalls.
module tb_bp_cfg_boot_sequencer;

    typedef struct packed {
        logic [7:0]  core;
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start      [2];
    logic [7:0]  rom_addr   [2];
    logic        rom_v      [2];
    logic [47:0] rom_q      [2];
    logic        cfg_v      [2];
    logic        ready      [2];
    logic [7:0]  cfg_core   [2];
    logic [15:0] cfg_addr   [2];
    logic [63:0] cfg_data   [2];
    logic        busy       [2];
    logic        done       [2];

    logic        start_req  [2];
    logic        rand_mode;
    logic        scramble;

    wr_t         exp_tab    [2][32];
    int          exp_len    [2];
    int          idx        [2];
    int          cyc        [2];
    int          run_cyc    [2];
    logic        in_done    [2];
    logic        done_due   [2];
    logic        stall      [2];
    logic [88:0] held       [2];

    int          n_checks;
    int          n_errors;

    bp_cfg_boot_sequencer #(.num_core_p(2), .ucode_els_p(4)) dut_a (
        .clk_i(clk), .reset_i(rst), .start_i(start[0]),
        .rom_addr_o(rom_addr[0]), .rom_v_o(rom_v[0]), .rom_data_i(rom_q[0]),
        .cfg_v_o(cfg_v[0]), .cfg_ready_i(ready[0]), .cfg_core_o(cfg_core[0]),
        .cfg_addr_o(cfg_addr[0]), .cfg_data_o(cfg_data[0]),
        .busy_o(busy[0]), .done_o(done[0])
    );

    bp_cfg_boot_sequencer #(.num_core_p(1), .ucode_els_p(1)) dut_b (
        .clk_i(clk), .reset_i(rst), .start_i(start[1]),
        .rom_addr_o(rom_addr[1]), .rom_v_o(rom_v[1]), .rom_data_i(rom_q[1]),
        .cfg_v_o(cfg_v[1]), .cfg_ready_i(ready[1]), .cfg_core_o(cfg_core[1]),
        .cfg_addr_o(cfg_addr[1]), .cfg_data_o(cfg_data[1]),
        .busy_o(busy[1]), .done_o(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM holding 0xA0+p; optionally trashed once the word has been presented.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rom_v[k]) rom_q[k] <= 48'hA0 + 48'(rom_addr[k]);
            else if (scramble) rom_q[k] <= '1;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic build_trace(input int k, input int ncore, input int nels);
        int n;
        n = 0;
        for (int c = 0; c < ncore; c++) begin
            exp_tab[k][n++] = {8'(c), 16'h0000, 64'd1};
            exp_tab[k][n++] = {8'(c), 16'h0001, 64'(c)};
            for (int p = 0; p < nels; p++)
                exp_tab[k][n++] = {8'(c), 16'(32'h8000 + p), 64'(32'hA0 + p)};
            exp_tab[k][n++] = {8'(c), 16'h0002, 64'd1};
        end
        for (int c = 0; c < ncore; c++)
            exp_tab[k][n++] = {8'(c), 16'h0000, 64'd0};
        exp_len[k] = n;
    endtask

    // One cycle: apply start, choose ready for the next edge, then compare against the model.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            start[k] = start_req[k];
            if (rst) begin
                idx[k] = 0; cyc[k] = 0; in_done[k] = 1'b0; done_due[k] = 1'b0; stall[k] = 1'b0;
                chk($sformatf("reset_state_%0d", k),
                    128'({cfg_v[k], rom_v[k], busy[k], done[k], cfg_core[k], cfg_addr[k], cfg_data[k]}),
                    128'(0));
            end else begin
                ready[k] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                if (busy[k]) cyc[k]++;
                if (stall[k])
                    chk($sformatf("stall_hold_%0d", k),
                        128'({cfg_v[k], cfg_core[k], cfg_addr[k], cfg_data[k]}), 128'(held[k]));
                stall[k] = 1'b0;
                if (in_done[k] || done_due[k]) begin
                    chk($sformatf("done_state_%0d", k),
                        128'({done[k], busy[k], cfg_v[k], rom_v[k]}), 128'(4'b1000));
                    if (done_due[k]) run_cyc[k] = cyc[k];
                    done_due[k] = 1'b0;
                    in_done[k]  = 1'b1;
                    if (start[k]) begin
                        in_done[k] = 1'b0; idx[k] = 0; cyc[k] = 0;
                    end
                end else if (idx[k] >= exp_len[k]) begin
                    chk($sformatf("overrun_%0d", k), 128'(idx[k]), 128'(exp_len[k] - 1));
                end else if (cfg_v[k]) begin
                    chk($sformatf("write_%0d_%0d", k, idx[k]),
                        128'({cfg_core[k], cfg_addr[k], cfg_data[k], busy[k], done[k]}),
                        128'({exp_tab[k][idx[k]], 1'b1, 1'b0}));
                    if (ready[k]) begin
                        idx[k]++;
                        if (idx[k] == exp_len[k]) done_due[k] = 1'b1;
                    end else begin
                        stall[k] = 1'b1;
                        held[k]  = {cfg_v[k], cfg_core[k], cfg_addr[k], cfg_data[k]};
                    end
                end else begin
                    chk($sformatf("fetch_%0d_%0d", k, idx[k]),
                        128'({rom_v[k], rom_addr[k], busy[k], done[k]}),
                        128'({1'b1, 8'(exp_tab[k][idx[k]].addr - 16'h8000), 1'b1, 1'b0}));
                end
            end
        end
    endtask

    task automatic run_until_done(input int k, input int budget);
        int n;
        n = 0;
        while (!in_done[k] && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("reach_done_%0d", k), 128'(in_done[k]), 128'(1));
    endtask

    task automatic pulse_start(input logic a, input logic b);
        start_req[0] = a;
        start_req[1] = b;
        tick();
        start_req[0] = 1'b0;
        start_req[1] = 1'b0;
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        rand_mode = 1'b0;
        scramble = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; start_req[k] = 1'b0; ready[k] = 1'b1;
            run_cyc[k] = 0; idx[k] = 0; cyc[k] = 0;
            in_done[k] = 1'b0; done_due[k] = 1'b0; stall[k] = 1'b0; held[k] = '0;
        end
        build_trace(0, 2, 4);
        build_trace(1, 1, 1);

        // Hand-derived anchors for the expected traces.
        chk("pin_len_a", 128'(exp_len[0]), 128'(16));
        chk("pin_len_b", 128'(exp_len[1]), 128'(5));
        chk("pin_a0_freeze", 128'(exp_tab[0][0]), 128'({8'd0, 16'h0000, 64'd1}));
        chk("pin_a3_ucode1", 128'(exp_tab[0][3]), 128'({8'd0, 16'h8001, 64'hA1}));
        chk("pin_a8_id1", 128'(exp_tab[0][8]), 128'({8'd1, 16'h0001, 64'd1}));
        chk("pin_a15_unfreeze1", 128'(exp_tab[0][15]), 128'({8'd1, 16'h0000, 64'd0}));
        chk("pin_b2_ucode0", 128'(exp_tab[1][2]), 128'({8'd0, 16'h8000, 64'hA0}));

        repeat (3) tick();
        rst = 1'b0;

        // Ready tied high, plus a start pulse while busy that must be ignored.
        tick();
        tick();
        pulse_start(1'b1, 1'b0);
        run_until_done(0, 200);
        run_until_done(1, 200);
        chk("cycles_a", 128'(run_cyc[0]), 128'(24));
        chk("cycles_b", 128'(run_cyc[1]), 128'(6));

        // Random ready stalls.
        rand_mode = 1'b1;
        pulse_start(1'b1, 1'b1);
        run_until_done(0, 400);
        run_until_done(1, 400);

        // ROM output trashed after each presentation while stalls continue.
        scramble = 1'b1;
        pulse_start(1'b1, 1'b1);
        run_until_done(0, 400);
        run_until_done(1, 400);

        // Reset in SEND of core 1, pc 2.
        pulse_start(1'b1, 1'b0);
        n = 0;
        while (!(cfg_v[0] && cfg_core[0] == 8'd1 && cfg_addr[0] == 16'h8002) && n < 400) begin
            tick();
            n++;
        end
        chk("reach_c1_p2", 128'({cfg_v[0], cfg_core[0], cfg_addr[0]}), 128'({1'b1, 8'd1, 16'h8002}));
        #2 rst = 1'b1;
        #1 chk("async_reset",
               128'({cfg_v[0], rom_v[0], busy[0], done[0], cfg_core[0], cfg_addr[0], cfg_data[0]}),
               128'(0));
        tick();
        tick();
        rst = 1'b0;
        run_until_done(0, 400);
        run_until_done(1, 400);

        // Restart from DONE with ready tied high: full trace and timing repeat.
        rand_mode = 1'b0;
        scramble = 1'b0;
        pulse_start(1'b1, 1'b0);
        run_until_done(0, 200);
        chk("cycles_a_rerun", 128'(run_cyc[0]), 128'(24));
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
